// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the buffered UART transmitter:
//   - serializer state encoding (fixed, legacy-compatible constants)
//   - parity mode codes
//   - data length decode helpers
// ----------------------------------------------------------------------------
package uart_pkg;

  // Serializer states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Parity mode codes (code 3 behaves as "none")
  localparam logic [1:0] PAR_NONE  = 2'd0;
  localparam logic [1:0] PAR_EVEN  = 2'd1;
  localparam logic [1:0] PAR_ODD   = 2'd2;
  localparam logic [1:0] PAR_NONE3 = 2'd3;

  // Index of the last data bit: code 0..3 -> 5..8 bits -> last index 4..7.
  function automatic logic [2:0] last_bit_index(input logic [1:0] code);
    return {1'b1, code};
  endfunction

  // Mask keeping only the bits that belong to the selected data length.
  function automatic logic [7:0] data_mask(input logic [1:0] code);
    return 8'hFF >> (2'd3 - code);
  endfunction

  function automatic logic parity_enabled(input logic [1:0] mode);
    logic en;
    case (mode)
      PAR_EVEN, PAR_ODD:  en = 1'b1;
      PAR_NONE, PAR_NONE3: en = 1'b0;
      default:            en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// ----------------------------------------------------------------------------
// uart_fifo
// Synchronous FIFO with occupancy count. Full/empty/count are registered;
// the head entry is read asynchronously from the storage array so a word
// written into an empty FIFO is visible to the consumer on the next cycle.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset (empties the FIFO)
//   push   in   write request; ignored while full
//   din    in   write data
//   pop    in   read request; ignored while empty
//   dout   out  head entry
//   count  out  number of stored entries (0..DEPTH)
//   full   out  FIFO holds DEPTH entries
//   empty  out  FIFO holds no entries
// ----------------------------------------------------------------------------
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg, count_next;
  logic             full_reg, empty_reg;
  logic             do_push, do_pop;

  assign do_push = push & ~full_reg;
  assign do_pop  = pop & ~empty_reg;

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage has no reset so it can map onto RAM resources.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; full and empty
  // come from the count so equal pointers are never ambiguous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == (AW+1)'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign full  = full_reg;
  assign empty = empty_reg;

endmodule

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
// Buffered UART transmitter: bytes are queued in a FIFO and serialized with
// a runtime-configurable frame format (5..8 data bits, none/even/odd parity,
// one or two stop bits, runtime baud divisor). The frame format is captured
// when a byte is popped, so configuration changes only affect later frames.
//
// Ports:
//   i_Clock         in   sole clock, rising edge
//   i_Reset_n       in   synchronous active-low reset
//   i_Clks_Per_Bit  in   clocks per bit (0 and 1 behave as 2)
//   i_Data_Bits     in   data length code 0..3 -> 5..8 bits
//   i_Parity_Mode   in   0/3 none, 1 even, 2 odd
//   i_Two_Stop      in   1 = two stop bits
//   i_Tx_DV         in   write strobe for i_Tx_Byte
//   i_Tx_Byte       in   byte to queue
//   o_Tx_Ready      out  FIFO not full
//   o_Fifo_Count    out  queued entries
//   o_Overflow      out  pulse: write attempted while full (byte dropped)
//   o_Tx_Active     out  high from first start-bit cycle to end of last stop bit
//   o_Tx_Serial     out  serial line, idle high
//   o_Tx_Done       out  pulse after each completed frame
// ----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset_n,
  input  logic [DIV_W-1:0]            i_Clks_Per_Bit,
  input  logic [1:0]                  i_Data_Bits,
  input  logic [1:0]                  i_Parity_Mode,
  input  logic                        i_Two_Stop,
  input  logic                        i_Tx_DV,
  input  logic [7:0]                  i_Tx_Byte,
  output logic                        o_Tx_Ready,
  output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count,
  output logic                        o_Overflow,
  output logic                        o_Tx_Active,
  output logic                        o_Tx_Serial,
  output logic                        o_Tx_Done
);

  logic [2:0]       state_reg;
  logic [DIV_W-1:0] div_reg, clk_cnt_reg;
  logic [2:0]       bit_cnt_reg, last_bit_reg;
  logic [7:0]       data_reg;
  logic             parity_en_reg, parity_bit_reg, two_stop_reg, stop_cnt_reg;
  logic             serial_reg, active_reg, done_reg, overflow_reg;

  logic [7:0] fifo_dout, load_data;
  logic       fifo_full, fifo_empty;
  logic       period_end, frame_end, load;

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (i_Clock),
    .rst_n (i_Reset_n),
    .push  (i_Tx_DV),
    .din   (i_Tx_Byte),
    .pop   (load),
    .dout  (fifo_dout),
    .count (o_Fifo_Count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign load_data  = fifo_dout & data_mask(i_Data_Bits);
  assign period_end = (clk_cnt_reg == div_reg - DIV_W'(1));
  // Last stop period: stop_cnt_reg reaches 1 only when two stop bits are used.
  assign frame_end  = (state_reg == ST_STOP) && period_end &&
                      (stop_cnt_reg == two_stop_reg);
  // A new frame starts from IDLE or directly at the end of the previous one,
  // which gives gap-free back-to-back frames.
  assign load       = ((state_reg == ST_IDLE) || frame_end) && !fifo_empty;

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_reg      <= ST_IDLE;
      div_reg        <= DIV_W'(2);
      clk_cnt_reg    <= '0;
      bit_cnt_reg    <= '0;
      last_bit_reg   <= '0;
      data_reg       <= '0;
      parity_en_reg  <= 1'b0;
      parity_bit_reg <= 1'b0;
      two_stop_reg   <= 1'b0;
      stop_cnt_reg   <= 1'b0;
      serial_reg     <= 1'b1;
      active_reg     <= 1'b0;
      done_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      done_reg     <= frame_end;
      overflow_reg <= i_Tx_DV & fifo_full;

      if (state_reg != ST_IDLE) begin
        clk_cnt_reg <= period_end ? '0 : clk_cnt_reg + DIV_W'(1);
      end

      case (state_reg)
        ST_IDLE: begin
          serial_reg <= 1'b1;
          active_reg <= 1'b0;
        end
        ST_START: begin
          if (period_end) begin
            state_reg  <= ST_DATA;
            serial_reg <= data_reg[0];
          end
        end
        ST_DATA: begin
          if (period_end) begin
            if (bit_cnt_reg == last_bit_reg) begin
              state_reg  <= parity_en_reg ? ST_PARITY : ST_STOP;
              serial_reg <= parity_en_reg ? parity_bit_reg : 1'b1;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              serial_reg  <= data_reg[bit_cnt_reg + 3'd1];
            end
          end
        end
        ST_PARITY: begin
          if (period_end) begin
            state_reg  <= ST_STOP;
            serial_reg <= 1'b1;
          end
        end
        ST_STOP: begin
          if (period_end) begin
            if (stop_cnt_reg == two_stop_reg) begin
              state_reg  <= ST_IDLE;
              active_reg <= 1'b0;
              serial_reg <= 1'b1;
            end else begin
              stop_cnt_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg  <= ST_IDLE;
          serial_reg <= 1'b1;
          active_reg <= 1'b0;
        end
      endcase

      // Frame start overrides the end-of-frame transition above.
      if (load) begin
        state_reg      <= ST_START;
        serial_reg     <= 1'b0;
        active_reg     <= 1'b1;
        clk_cnt_reg    <= '0;
        bit_cnt_reg    <= '0;
        stop_cnt_reg   <= 1'b0;
        data_reg       <= load_data;
        last_bit_reg   <= last_bit_index(i_Data_Bits);
        div_reg        <= (i_Clks_Per_Bit < DIV_W'(2)) ? DIV_W'(2) : i_Clks_Per_Bit;
        parity_en_reg  <= parity_enabled(i_Parity_Mode);
        parity_bit_reg <= (^load_data) ^ (i_Parity_Mode == PAR_ODD);
        two_stop_reg   <= i_Two_Stop;
      end
    end
  end

  assign o_Tx_Ready  = ~fifo_full;
  assign o_Overflow  = overflow_reg;
  assign o_Tx_Active = active_reg;
  assign o_Tx_Serial = serial_reg;
  assign o_Tx_Done   = done_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo (FIFO_DEPTH=4). Expected line activity
// is generated per frame from the frame format: start bit, LSB-first data,
// optional parity, stop bits, each lasting max(D,2) clocks, with a done pulse
// on the cycle after each frame.
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int DEPTH = 4;
  localparam int DIV_W = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DIV_W-1:0] cpb;
  logic [1:0]       dbits, pmode;
  logic             two_stop, dv;
  logic [7:0]       tx_byte;
  logic             ready, ovf, active, serial, done;
  logic [CW-1:0]    fcount;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .FIFO_DEPTH (DEPTH),
    .DIV_W      (DIV_W)
  ) dut (
    .i_Clock        (clk),
    .i_Reset_n      (rst_n),
    .i_Clks_Per_Bit (cpb),
    .i_Data_Bits    (dbits),
    .i_Parity_Mode  (pmode),
    .i_Two_Stop     (two_stop),
    .i_Tx_DV        (dv),
    .i_Tx_Byte      (tx_byte),
    .o_Tx_Ready     (ready),
    .o_Fifo_Count   (fcount),
    .o_Overflow     (ovf),
    .o_Tx_Active    (active),
    .o_Tx_Serial    (serial),
    .o_Tx_Done      (done)
  );

  int vectors = 0;
  int miscompares = 0;

  // Expected per-cycle {serial, active, done}
  logic [2:0] exp_q[$];
  int         kpos;
  bit         pending;
  logic [7:0] tx_bytes[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, expv);
    end
  endtask

  task automatic push_cycles(input bit line, input bit act, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      exp_q.push_back({line, act, pending});
      pending = 1'b0;
    end
  endtask

  task automatic add_frame(input logic [7:0] b, input int cpb_v, input int code,
                           input int par, input bit two);
    int d;
    int nbits;
    bit p;
    d     = (cpb_v < 2) ? 2 : cpb_v;
    nbits = code + 5;
    p     = 1'b0;
    push_cycles(1'b0, 1'b1, d);
    for (int i = 0; i < nbits; i++) begin
      push_cycles(b[i], 1'b1, d);
      p ^= b[i];
    end
    if (par == 1)      push_cycles(p, 1'b1, d);
    else if (par == 2) push_cycles(!p, 1'b1, d);
    push_cycles(1'b1, 1'b1, two ? 2 * d : d);
    pending = 1'b1;
  endtask

  task automatic close_expect();
    push_cycles(1'b1, 1'b0, 2);
  endtask

  task automatic clear_expect();
    exp_q.delete();
    kpos    = 0;
    pending = 1'b0;
  endtask

  // Consecutive-cycle writes from an idle, empty transmitter. The first byte
  // is popped one cycle after it lands, so the count after write i (i>=1) is
  // min(i, DEPTH) and writes beyond DEPTH+1 overflow.
  task automatic write_burst(input int n);
    int c;
    dv = 1'b1;
    for (int i = 0; i < n; i++) begin
      tx_byte = tx_bytes[i];
      tick();
      c = (i == 0) ? 1 : ((i < DEPTH) ? i : DEPTH);
      check("fifo", 32'({fcount, ready, ovf}), 32'({CW'(c), c < DEPTH, i > DEPTH}));
      if (i == 0) begin
        check("idle", 32'({serial, active, done}), 32'(3'b100));
      end else begin
        check("line", 32'({serial, active, done}), 32'(exp_q[kpos]));
        kpos++;
      end
    end
    dv = 1'b0;
  endtask

  task automatic check_range(input int upto);
    while (kpos < upto) begin
      tick();
      check("line", 32'({serial, active, done, ovf}), 32'({exp_q[kpos], 1'b0}));
      kpos++;
    end
  endtask

  task automatic run_frames(input int n, input int cpb_v, input int code,
                            input int par, input bit two);
    int nf;
    cpb      = DIV_W'(cpb_v);
    dbits    = 2'(code);
    pmode    = 2'(par);
    two_stop = two;
    clear_expect();
    nf = (n < DEPTH + 1) ? n : DEPTH + 1;
    for (int i = 0; i < nf; i++) add_frame(tx_bytes[i], cpb_v, code, par, two);
    close_expect();
    write_burst(n);
    check_range(exp_q.size());
    $display("frames: %0d bytes, D=%0d, len=%0d, parity=%0d, stop=%0d, first=%02h, %0d cycles",
             n, cpb_v, code + 5, par, two ? 2 : 1, tx_bytes[0], exp_q.size());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    // Reset with a write strobe held high: the write must be ignored.
    rst_n    = 1'b0;
    dv       = 1'b1;
    tx_byte  = 8'hA5;
    cpb      = DIV_W'(4);
    dbits    = 2'd3;
    pmode    = 2'd0;
    two_stop = 1'b0;
    clear_expect();
    tick(); tick(); tick();
    check("reset_out", 32'({serial, active, done, ovf, ready, fcount}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, CW'(0)}));
    rst_n = 1'b1;
    dv    = 1'b0;
    tick();
    check("post_reset", 32'({serial, active, fcount}), 32'({1'b1, 1'b0, CW'(0)}));
    $display("reset: outputs checked");

    // D=4 8N1 0x55: 40-clock frame
    tx_bytes = '{8'h55};
    run_frames(1, 4, 3, 0, 1'b0);
    check("frame_len_8n1", 32'(exp_q.size()), 32'(40 + 2));

    // D=3 7E2 0x03: 33-clock frame
    tx_bytes = '{8'h03};
    run_frames(1, 3, 2, 1, 1'b1);

    // D=2 5O1 0xFF: upper bits ignored
    tx_bytes = '{8'hFF};
    run_frames(1, 2, 0, 2, 1'b0);

    // Divisor 0 and 1 behave as 2
    tx_bytes = '{8'h96};
    run_frames(1, 0, 3, 1, 1'b0);
    tx_bytes = '{8'h3C};
    run_frames(1, 1, 1, 0, 1'b1);

    // Overflow: 6 writes in 6 cycles, 5 frames back-to-back
    tx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_frames(6, 10, 3, 0, 1'b0);

    // Reset in the middle of the first frame's data with 3 bytes queued
    cpb = DIV_W'(4); dbits = 2'd3; pmode = 2'd0; two_stop = 1'b0;
    tx_bytes = '{8'hC3, 8'h5A, 8'h0F, 8'hF0};
    clear_expect();
    for (int i = 0; i < 4; i++) add_frame(tx_bytes[i], 4, 3, 0, 1'b0);
    write_burst(4);
    check_range(13);
    rst_n = 1'b0;
    dv    = 1'b1;
    tick();
    check("abort_reset", 32'({serial, active, done, ovf, ready, fcount}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, CW'(0)}));
    rst_n = 1'b1;
    dv    = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("abort_quiet", 32'({serial, active, done, fcount}), 32'({3'b100, CW'(0)}));
    end
    $display("abort: reset during data, queue flushed");
    clear_expect();

    // Data length change mid-frame affects only the next frame
    cpb = DIV_W'(4); dbits = 2'd3; pmode = 2'd0; two_stop = 1'b0;
    tx_bytes = '{8'hB7, 8'hE9};
    clear_expect();
    add_frame(tx_bytes[0], 4, 3, 0, 1'b0);
    add_frame(tx_bytes[1], 4, 0, 0, 1'b0);
    close_expect();
    write_burst(2);
    check_range(20);
    dbits = 2'd0;
    check_range(exp_q.size());
    $display("cfg change: 8-bit frame then 5-bit frame, %0d cycles", exp_q.size());

    // Randomized formats and burst sizes
    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(1, 6);
      tx_bytes.delete();
      for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
      run_frames(n, $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
